// File: rtl/data_mem_ctrl.sv
// Byte-addressed, little-endian data memory: byte/half/word loads and stores, registered
// completion strobe, range/misalignment faults. Define DATA_MEM_MISALIGN_SPLIT_EN for two-cycle split access.
module data_mem_ctrl #(
   parameter int DEPTH = 256,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req,
   input  logic          we,
   input  logic [1:0]    size,
   input  logic          unsigned_ld,
   input  logic [AW-1:0] a,
   input  logic [31:0]   wd,
   output logic          ready,
   output logic          rvalid,
   output logic [31:0]   rd,
   output logic          fault,
   output logic          dbg_split
);

   // Handshake: a request is taken on a rising edge where req=1 and ready=1; every taken
   // request yields exactly one rvalid pulse (fault qualifies it), req while ready=0 is ignored.

   localparam int LW = $clog2(DEPTH);
   localparam int KW = AW - 2;

   logic [31:0]   r_mem [DEPTH];
   logic          r_rvalid;
   logic          r_fault;
   logic [31:0]   r_rd;

   logic [KW-1:0] w_k;
   logic [1:0]    w_o;
   logic [LW-1:0] w_idx;
   logic          w_k_in;
   logic          w_misal;
   logic          w_fault;
   logic          w_accept;
   logic [7:0]    w_size_mask;
   logic [7:0]    w_be8;
   logic [63:0]   w_wd64;
   logic [31:0]   w_lo_part;

   function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] sz,
                                            input logic uns);
      case (sz)
         2'b00:   f_extend = uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
         2'b01:   f_extend = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
         default: f_extend = d;
      endcase
   endfunction

   assign w_k       = a[AW-1:2];
   assign w_o       = a[1:0];
   assign w_idx     = w_k[LW-1:0];
   assign w_k_in    = ((w_k >> LW) == '0);
   assign w_misal   = ((size == 2'b01) && (w_o == 2'b11)) ||
                      ((size == 2'b10) && (w_o != 2'b00));
   assign w_accept  = req && ready;
   assign w_wd64    = 64'(wd) << {w_o, 3'b000};
   assign w_lo_part = r_mem[w_idx] >> {w_o, 3'b000};

   // Byte enables over two adjacent words: lanes [3:0] hit word k, [7:4] hit word k+1.
   always_comb begin
      w_size_mask = 8'h00;
      case (size)
         2'b00:   w_size_mask = 8'h01;
         2'b01:   w_size_mask = 8'h03;
         2'b10:   w_size_mask = 8'h0F;
         default: w_size_mask = 8'h00;
      endcase
      w_be8 = w_size_mask << w_o;
   end

   assign rvalid = r_rvalid;
   assign fault  = r_fault;
   assign rd     = r_rd;

`ifdef DATA_MEM_MISALIGN_SPLIT_EN
   typedef enum logic {S_IDLE, S_SPLIT} state_t;

   state_t        r_state;
   logic [31:0]   r_part;
   logic [1:0]    r_o;
   logic [1:0]    r_size;
   logic          r_uns;
   logic          r_we;
   logic [LW-1:0] r_idx1;
   logic [3:0]    r_hi_be;
   logic [31:0]   r_hi_data;

   logic          w_k1_in;
   logic          w_split;
   logic [31:0]   w_merged;

   // DEPTH is a power of two, so word k+1 exists unless k is all ones.
   assign w_k1_in   = w_k_in && (w_idx != '1);
   assign w_fault   = (size == 2'b11) || !w_k_in || (w_misal && !w_k1_in);
   assign w_split   = w_misal && !w_fault;
   assign w_merged  = r_part | (r_mem[r_idx1] << {3'd4 - {1'b0, r_o}, 3'b000});
   assign ready     = (r_state == S_IDLE);
   assign dbg_split = (r_state == S_SPLIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rvalid  <= 1'b0;
         r_fault   <= 1'b0;
         r_rd      <= '0;
         r_part    <= '0;
         r_o       <= '0;
         r_size    <= '0;
         r_uns     <= 1'b0;
         r_we      <= 1'b0;
         r_idx1    <= '0;
         r_hi_be   <= '0;
         r_hi_data <= '0;
      end else begin
         r_rvalid <= 1'b0;
         r_fault  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_split) begin
                     r_state   <= S_SPLIT;
                     r_part    <= w_lo_part;
                     r_o       <= w_o;
                     r_size    <= size;
                     r_uns     <= unsigned_ld;
                     r_we      <= we;
                     r_idx1    <= w_idx + LW'(1);
                     r_hi_be   <= w_be8[7:4];
                     r_hi_data <= w_wd64[63:32];
                  end else begin
                     r_rvalid <= 1'b1;
                     r_fault  <= w_fault;
                     if (w_fault)
                        r_rd <= '0;
                     else if (!we)
                        r_rd <= f_extend(w_lo_part, size, unsigned_ld);
                  end
               end
            end
            S_SPLIT: begin
               r_state  <= S_IDLE;
               r_rvalid <= 1'b1;
               if (!r_we)
                  r_rd <= f_extend(w_merged, r_size, r_uns);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (w_accept && we && !w_fault && w_be8[l])
            r_mem[w_idx][8*l +: 8] <= w_wd64[8*l +: 8];
         if ((r_state == S_SPLIT) && r_we && r_hi_be[l])
            r_mem[r_idx1][8*l +: 8] <= r_hi_data[8*l +: 8];
      end
   end

`else
   logic w_unused;

   assign w_fault   = (size == 2'b11) || !w_k_in || w_misal;
   assign ready     = 1'b1;
   assign dbg_split = 1'b0;
   assign w_unused  = ^{w_be8[7:4], w_wd64[63:32]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_fault  <= 1'b0;
         r_rd     <= '0;
      end else begin
         r_rvalid <= w_accept;
         r_fault  <= w_accept && w_fault;
         if (w_accept) begin
            if (w_fault)
               r_rd <= '0;
            else if (!we)
               r_rd <= f_extend(w_lo_part, size, unsigned_ld);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (w_accept && we && !w_fault && w_be8[l])
            r_mem[w_idx][8*l +: 8] <= w_wd64[8*l +: 8];
      end
   end
`endif

endmodule
